// File: rtl/sprite_line_fetcher.sv
// Per-scanline tile fetcher: walks COLS tile columns, looks up each sprite row
// word and fills the back bank of a ping-pong line buffer for the display side.
module sprite_line_fetcher #(
    parameter int COLS = 80
) (
    input  logic        CLK_100,
    input  logic        RESET_N,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    output logic        map_req,
    output logic [6:0]  map_col,
    output logic [4:0]  map_row,
    input  logic        map_ack,
    input  logic [7:0]  map_index,
    output logic [7:0]  get_index,
    output logic [3:0]  get_line,
    input  logic [15:0] get_data,
    input  logic [6:0]  pix_col,
    output logic [15:0] pix_data,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LOOK,
        WRITE
    } state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [7:0] NUM_COLS = 8'(COLS);

    state_t      state;
    state_t      state_next;
    logic        disp_bank;
    logic [6:0]  col;
    logic [15:0] wdata;
    logic        last_col;
    logic [15:0] buffer [2][COLS];

    // Only rows 0..511 exist in the tile map; the top scanline bit is ignored.
    logic unused_line_msb;
    assign unused_line_msb = line_y[9];

    assign last_col = (col == LAST_COL);
    assign map_col  = col;

    always_ff @(posedge CLK_100) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        map_req    = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            IDLE:  state_next = IDLE;
            REQ: begin
                map_req = 1'b1;
                if (map_ack) begin
                    state_next = LOOK;
                end
            end
            LOOK:  state_next = WRITE;
            WRITE: begin
                if (last_col) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        // A new line always wins, whatever the fetch was doing.
        if (line_start) begin
            state_next = REQ;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_100) begin
        if (!RESET_N) begin
            disp_bank <= 1'b0;
            map_row   <= '0;
            get_line  <= '0;
            col       <= '0;
            get_index <= '0;
            wdata     <= '0;
            overrun   <= 1'b0;
        end else begin
            if (line_start) begin
                disp_bank <= ~disp_bank;
                map_row   <= line_y[8:4];
                get_line  <= line_y[3:0];
                col       <= '0;
                // Starting on the final WRITE is a clean hand-over, not an overrun.
                if (busy && !done) begin
                    overrun <= 1'b1;
                end
            end else if (state == WRITE && !last_col) begin
                col <= col + 7'd1;
            end
            if (state == REQ && map_ack) begin
                get_index <= map_index;
            end
            if (state == LOOK) begin
                wdata <= get_data;
            end
        end
    end

    // NOTE: the line buffer is deliberately not reset; only the write is gated by reset.
    always_ff @(posedge CLK_100) begin
        if (RESET_N && state == WRITE) begin
            buffer[~disp_bank][col] <= wdata;
        end
    end

    always_ff @(posedge CLK_100) begin
        if (!RESET_N) begin
            pix_data <= '0;
        end else if ({1'b0, pix_col} < NUM_COLS) begin
            pix_data <= buffer[disp_bank][pix_col];
        end else begin
            pix_data <= '0;
        end
    end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Self-checking bench for sprite_line_fetcher: a tile-map responder with random
// indices/ack delays and a bank-level model of the ping-pong line buffer.
module tb_sprite_line_fetcher;

    localparam int COLS = 80;

    logic        CLK_100;
    logic        RESET_N;
    logic        line_start;
    logic [9:0]  line_y;
    logic        map_req;
    logic [6:0]  map_col;
    logic [4:0]  map_row;
    logic        map_ack;
    logic [7:0]  map_index;
    logic [7:0]  get_index;
    logic [3:0]  get_line;
    logic [15:0] get_data;
    logic [6:0]  pix_col;
    logic [15:0] pix_data;
    logic        busy;
    logic        done;
    logic        overrun;

    sprite_line_fetcher #(.COLS(COLS)) dut (
        .CLK_100   (CLK_100),
        .RESET_N   (RESET_N),
        .line_start(line_start),
        .line_y    (line_y),
        .map_req   (map_req),
        .map_col   (map_col),
        .map_row   (map_row),
        .map_ack   (map_ack),
        .map_index (map_index),
        .get_index (get_index),
        .get_line  (get_line),
        .get_data  (get_data),
        .pix_col   (pix_col),
        .pix_data  (pix_data),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    // sprite_ram stub
    assign get_data = {get_index, 4'h0, get_line};

    initial CLK_100 = 1'b0;
    always #5 CLK_100 = ~CLK_100;

    typedef struct {
        int          due;
        bit          bank;
        int          col;
        logic [15:0] w;
    } pend_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_ls  = 0;

    // responder configuration
    int delay_col  = -1;
    int delay_n    = 0;
    int pix_fixed  = -1;
    bit rand_delay = 0;
    bit idx_rand   = 0;
    bit idle_noise = 0;

    // responder / model state
    int          exp_col  = 0;
    int          req_wait = -1;
    int          fin_edge = -1;
    logic [6:0]  hold_col;
    logic [4:0]  m_row  = '0;
    logic [3:0]  m_line = '0;
    bit          m_disp   = 0;
    bit          m_active = 0;
    bit          m_over   = 0;
    logic [15:0] m_word  [2][128];
    bit          m_known [2][128];
    pend_t       pend[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic forget_pending();
        foreach (pend[i]) m_known[pend[i].bank][pend[i].col] = 0;
        pend.delete();
    endtask

    // One clock: respond to the DUT, advance the edge, update the model, check.
    task automatic tick();
        bit rst;
        bit ls;
        bit rd_bank;
        int rd_col;
        rst = !RESET_N;
        ls  = line_start;
        map_ack = 1'b0;
        pix_col = (pix_fixed >= 0) ? 7'(pix_fixed) : 7'($urandom_range(0, 127));
        if (rst) begin
            map_ack   = 1'($urandom_range(0, 1));
            map_index = 8'($urandom_range(0, 255));
        end else if (!ls && map_req) begin
            if (req_wait < 0) begin
                check("req_col", map_col, exp_col);
                check("req_row", map_row, m_row);
                check("req_line", get_line, m_line);
                hold_col = map_col;
                if (map_col == delay_col) req_wait = delay_n;
                else if (rand_delay)      req_wait = $urandom_range(0, 2);
                else                      req_wait = 0;
            end else begin
                check("req_hold", map_col, hold_col);
            end
            if (req_wait > 0) begin
                req_wait--;
            end else begin
                map_ack   = 1'b1;
                map_index = idx_rand ? 8'($urandom_range(0, 255)) : 8'(map_col + 128);
                pend.push_back('{cyc + 3, !m_disp, int'(map_col), {map_index, 4'h0, m_line}});
                if (map_col == COLS - 1) fin_edge = cyc + 3;
                exp_col++;
                req_wait = -1;
            end
        end else if (!ls) begin
            if (req_wait >= 0) begin
                check("req_drop", map_req, 1);
                req_wait = -1;
            end
            if (idle_noise) begin
                map_ack   = 1'($urandom_range(0, 1));
                map_index = 8'($urandom_range(0, 255));
            end
        end
        rd_bank = m_disp;
        rd_col  = int'(pix_col);

        @(posedge CLK_100);
        #1;
        cyc++;

        if (rst) begin
            forget_pending();
            m_disp = 0; m_active = 0; m_over = 0;
            fin_edge = -1; req_wait = -1; exp_col = 0;
        end else begin
            if (ls && m_active && fin_edge != cyc) begin
                m_over = 1;
                forget_pending();
            end
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == cyc) begin
                    m_word[pend[i].bank][pend[i].col]  = pend[i].w;
                    m_known[pend[i].bank][pend[i].col] = 1;
                    pend.delete(i);
                end
            end
            if (fin_edge == cyc) begin
                m_active = 0;
                fin_edge = -1;
            end
            if (ls) begin
                m_disp = !m_disp;
                m_row  = line_y[8:4];
                m_line = line_y[3:0];
                m_active = 1;
                fin_edge = -1; exp_col = 0; req_wait = -1;
            end
        end

        if (rst)                         check("pix_rst", pix_data, 0);
        else if (rd_col >= COLS)         check("pix_range", pix_data, 0);
        else if (m_known[rd_bank][rd_col]) check("pix_word", pix_data, m_word[rd_bank][rd_col]);
        check("busy", busy, m_active);
        check("done", done, m_active && (fin_edge == cyc + 1));
        check("overrun", overrun, m_over);
        if (!m_active) check("req_idle", map_req, 0);
    endtask

    task automatic start_line(input logic [9:0] y);
        line_y     = y;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        t_ls = cyc;
    endtask

    task automatic run_to_done(input int exp_off);
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (done === 1'b1) break;
        end
        check("done_seen", done, 1);
        if (exp_off >= 0) check("done_time", cyc + 1 - t_ls, exp_off);
    endtask

    task automatic wait_col(input int c);
        for (int i = 0; i < 3000; i++) begin
            if (map_req === 1'b1 && map_col == c) return;
            tick();
        end
        check("col_seen", map_col, c);
    endtask

    initial begin
        RESET_N    = 1'b0;
        line_start = 1'b0;
        line_y     = '0;
        map_ack    = 1'b0;
        map_index  = '0;
        pix_col    = '0;

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            line_start = 1'($urandom_range(0, 1));
            line_y     = 10'($urandom_range(0, 1023));
            tick();
            check("rst_map_req", map_req, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_overrun", overrun, 0);
            check("rst_pix_data", pix_data, 0);
            check("rst_get_index", get_index, 0);
            check("rst_get_line", get_line, 0);
            check("rst_map_col", map_col, 0);
            check("rst_map_row", map_row, 0);
        end
        line_start = 1'b0;
        RESET_N    = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("quiet_req", map_req, 0);

        // zero-wait line, index = col+128
        start_line(10'd37);
        run_to_done(240);
        tick();
        check("a_idle", busy, 0);
        check("a_cols", exp_col, COLS);

        // swap visible two cycles later; delayed ack on column 7
        pix_fixed = 5;
        idx_rand  = 1;
        delay_col = 7;
        delay_n   = 4;
        start_line(10'($urandom_range(0, 1023)));
        tick();
        check("swap_pix", pix_data, 16'h8505);
        pix_fixed = -1;
        run_to_done(244);
        tick();
        check("b_idle", busy, 0);
        delay_col = -1;

        // acks while idle are ignored
        idle_noise = 1;
        for (int i = 0; i < 12; i++) tick();
        idle_noise = 0;
        check("noise_busy", busy, 0);
        check("noise_req", map_req, 0);

        // overrun: restart during column 10
        rand_delay = 1;
        start_line(10'($urandom_range(0, 1023)));
        wait_col(10);
        rand_delay = 0;
        start_line(10'd100);
        check("ovr_flag", overrun, 1);
        check("ovr_row", map_row, 6);
        check("ovr_line", get_line, 4);
        check("ovr_col", map_col, 0);
        run_to_done(240);
        for (int i = 0; i < 4; i++) tick();
        check("ovr_sticky", overrun, 1);

        // mid-fetch reset at column 20
        start_line(10'($urandom_range(0, 1023)));
        wait_col(20);
        RESET_N = 1'b0;
        tick();
        check("mrst_busy", busy, 0);
        check("mrst_req", map_req, 0);
        RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // full line with random ack delays, then restart on its final WRITE
        rand_delay = 1;
        start_line(10'($urandom_range(0, 1023)));
        run_to_done(-1);
        check("e_cols", exp_col, COLS);
        rand_delay = 0;
        start_line(10'($urandom_range(0, 1023)));
        check("handover_ovr", overrun, 0);
        check("handover_busy", busy, 1);
        run_to_done(240);
        tick();
        check("f_idle", busy, 0);

        // out-of-range read column
        pix_fixed = 100;
        tick();
        check("range_pix", pix_data, 0);
        pix_fixed = -1;
        for (int i = 0; i < 20; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
